// File: rtl/cache_pkg.sv
// Shared geometry constants and controller state type for the 2-way, 4-set instruction cache.
package cache_pkg;

  localparam int unsigned NUM_SETS   = 4;
  localparam int unsigned NUM_WAYS   = 2;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned OFFSET_LSB = 2;
  localparam int unsigned INDEX_LSB  = 4;
  localparam int unsigned TAG_LSB    = 6;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned OFF_W      = 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_e;

endpackage

// File: rtl/lru.sv
// One recency bit per set for the 2-way cache; the victim is the way not touched most recently.
module lru
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] index,
  input  logic             update_en,
  input  logic             hit0,
  input  logic             hit1,
  output logic             victim_way
);

  // mru_q[s] = 1 means way 0 was used last, so way 1 is the victim
  logic [NUM_SETS-1:0] mru_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mru_q <= '0;
    end else if (update_en && (hit0 || hit1)) begin
      mru_q[index] <= hit0;
    end
  end

  assign victim_way = mru_q[index];

endmodule

// File: rtl/icache_ctrl.sv
// Read-only instruction cache controller: tag lookup, LRU victim choice and 4-beat line refill.
module icache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_data,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned TAG_W = ADDR_W - TAG_LSB;

  state_e                             state_q, state_d;
  logic [ADDR_W-1:0]                  addr_q;
  logic                               victim_q;
  logic [1:0]                         cnt_q;
  logic [NUM_WAYS-1:0][NUM_SETS-1:0]  valid_q;
  logic [TAG_W-1:0]                   tag_q  [NUM_WAYS][NUM_SETS];
  logic [DATA_W-1:0]                  data_q [NUM_WAYS][NUM_SETS][LINE_WORDS];

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] req_tag;
  logic             hit0, hit1, hit_way;
  logic             lru_update, lru_hit0, lru_hit1, lru_victim;
  logic             accept, beat_last;
  logic             unused_addr;

  assign idx         = addr_q[INDEX_LSB +: IDX_W];
  assign off         = addr_q[OFFSET_LSB +: OFF_W];
  assign req_tag     = addr_q[ADDR_W-1:TAG_LSB];
  assign unused_addr = ^addr_q[OFFSET_LSB-1:0];

  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == req_tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == req_tag);
  assign hit_way = ~hit0;  // way 0 wins if both ever hit

  assign accept    = (state_q == IDLE) && !flush && cpu_req_valid;
  assign beat_last = (state_q == REFILL) && mem_rdata_valid && (cnt_q == 2'd3);

  lru u_lru (
    .clk        (clk),
    .rst        (rst),
    .index      (idx),
    .update_en  (lru_update),
    .hit0       (lru_hit0),
    .hit1       (lru_hit1),
    .victim_way (lru_victim)
  );

  always_comb begin
    state_d        = state_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    lru_update     = 1'b0;
    lru_hit0       = 1'b0;
    lru_hit1       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit0 || hit1) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_data  = data_q[hit_way][idx][off];
          lru_update     = 1'b1;
          lru_hit0       = hit0;
          lru_hit1       = hit1 & ~hit0;
          state_d        = IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[ADDR_W-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
        if (mem_req_ready) state_d = REFILL;
      end
      REFILL: begin
        if (beat_last) state_d = RESP;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_data  = data_q[victim_q][idx][off];
        lru_update     = 1'b1;
        lru_hit0       = ~victim_q;
        lru_hit1       = victim_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      victim_q <= 1'b0;
      cnt_q    <= 2'd0;
      valid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) addr_q <= cpu_req_addr;
      if ((state_q == IDLE) && flush) valid_q <= '0;
      if ((state_q == LOOKUP) && !(hit0 || hit1)) victim_q <= lru_victim;
      // Victim goes invalid before its first beat lands, so an aborted refill never hits
      if ((state_q == MISS_REQ) && mem_req_ready) valid_q[victim_q][idx] <= 1'b0;
      if ((state_q == REFILL) && mem_rdata_valid) cnt_q <= cnt_q + 2'd1;
      if (beat_last) valid_q[victim_q][idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == REFILL) && mem_rdata_valid) begin
      data_q[victim_q][idx][cnt_q] <= mem_rdata;
      if (cnt_q == 2'd3) tag_q[victim_q][idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: fills, hits, LRU replacement, bus stalls, reset abort, flush.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_ready;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_data;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  icache_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_ready   (cpu_req_ready),
    .cpu_resp_valid  (cpu_resp_valid),
    .cpu_resp_data   (cpu_resp_data),
    .flush           (flush),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One fetch; on a miss the bench plays memory with beats base+0..base+3.
  // abort < 4 pulses rst just before that beat index instead of finishing the refill.
  task automatic fetch(input string tag, input logic [31:0] addr, input bit miss,
                       input logic [31:0] base, input int stall, input int gap,
                       input int abort, input logic [31:0] exp_word);
    int          cyc, nresp, unstable, wait_cnt;
    logic [31:0] line;
    line     = {addr[31:4], 4'h0};
    wait_cnt = 0;
    while (!cpu_req_ready && wait_cnt < 20) begin
      step();
      wait_cnt++;
    end
    check_eq({tag, "_ready"}, 32'(cpu_req_ready), 32'd1);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    step();
    cpu_req_valid = 1'b0;
    cpu_req_addr  = 32'hDEAD_BEEC;
    cyc = 1;
    if (!miss) begin
      check_eq({tag, "_hit_valid"}, 32'(cpu_resp_valid), 32'd1);
      check_eq({tag, "_hit_data"}, cpu_resp_data, exp_word);
      check_eq({tag, "_hit_nomem"}, 32'(mem_req_valid), 32'd0);
    end else begin
      nresp    = int'(cpu_resp_valid);
      unstable = 0;
      step();
      cyc++;
      check_eq({tag, "_mreq_valid"}, 32'(mem_req_valid), 32'd1);
      check_eq({tag, "_mreq_addr"}, mem_req_addr, line);
      for (int i = 0; i < stall; i++) begin
        step();
        cyc++;
        nresp += int'(cpu_resp_valid);
        if (!mem_req_valid || mem_req_addr !== line) unstable++;
      end
      mem_req_ready = 1'b1;
      step();
      cyc++;
      mem_req_ready = 1'b0;
      nresp += int'(cpu_resp_valid);
      for (int k = 0; k < 4; k++) begin
        if (k == abort) begin
          mem_rdata_valid = 1'b0;
          rst = 1'b1;
          step();
          rst = 1'b0;
          check_eq({tag, "_rst_ready"}, 32'(cpu_req_ready), 32'd1);
          check_eq({tag, "_rst_mreq"}, 32'(mem_req_valid), 32'd0);
          check_eq({tag, "_rst_resp"}, 32'(cpu_resp_valid), 32'd0);
          return;
        end
        for (int g = 0; g < gap; g++) begin
          mem_rdata_valid = 1'b0;
          step();
          cyc++;
          nresp += int'(cpu_resp_valid);
        end
        mem_rdata_valid = 1'b1;
        mem_rdata       = base + 32'(k);
        step();
        cyc++;
        if (k < 3) nresp += int'(cpu_resp_valid);
      end
      mem_rdata_valid = 1'b0;
      check_eq({tag, "_miss_valid"}, 32'(cpu_resp_valid), 32'd1);
      check_eq({tag, "_miss_data"}, cpu_resp_data, exp_word);
      check_eq({tag, "_latency"}, 32'(cyc), 32'(7 + stall + 4 * gap));
      check_eq({tag, "_early_resp"}, 32'(nresp), 32'd0);
      check_eq({tag, "_mreq_stable"}, 32'(unstable), 32'd0);
    end
    step();
    check_eq({tag, "_resp_drop"}, 32'(cpu_resp_valid), 32'd0);
    check_eq({tag, "_idle"}, 32'(cpu_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    cpu_req_valid   = 1'b0;
    cpu_req_addr    = '0;
    flush           = 1'b0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    @(posedge clk);
    step();
    rst = 1'b0;
    check_eq("rst_ready", 32'(cpu_req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    check_eq("rst_resp_data", cpu_resp_data, 32'd0);
    check_eq("rst_mreq_valid", 32'(mem_req_valid), 32'd0);
    check_eq("rst_mreq_addr", mem_req_addr, 32'd0);

    fetch("cold",    32'h0000_0044, 1'b1, 32'hA0, 0, 0, 4, 32'hA1);
    fetch("hit",     32'h0000_004C, 1'b0, 32'h0,  0, 0, 4, 32'hA3);
    fetch("way1",    32'h0000_0440, 1'b1, 32'hB0, 0, 0, 4, 32'hB0);
    fetch("way0",    32'h0000_0848, 1'b1, 32'hC0, 0, 0, 4, 32'hC2);
    fetch("rehit",   32'h0000_0444, 1'b0, 32'h0,  0, 0, 4, 32'hB1);
    fetch("stall",   32'h0000_0040, 1'b1, 32'hA0, 5, 2, 4, 32'hA0);
    fetch("keep1",   32'h0000_044C, 1'b0, 32'h0,  0, 0, 4, 32'hB3);
    fetch("abort",   32'h0000_0100, 1'b1, 32'hD0, 0, 0, 3, 32'h0);
    fetch("refetch", 32'h0000_0108, 1'b1, 32'hD0, 0, 0, 4, 32'hD2);
    fetch("set1",    32'h0000_001C, 1'b1, 32'hE0, 0, 0, 4, 32'hE3);

    // flush and request together: request is held for one cycle
    flush         = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h0000_0104;
    step();
    flush = 1'b0;
    check_eq("flush_held", 32'(cpu_req_ready), 32'd1);
    check_eq("flush_noresp", 32'(cpu_resp_valid), 32'd0);
    fetch("flush_req",  32'h0000_0104, 1'b1, 32'hF0, 0, 0, 4, 32'hF1);
    fetch("flush_set1", 32'h0000_0018, 1'b1, 32'h90, 0, 0, 4, 32'h92);
    fetch("post_hit",   32'h0000_0100, 1'b0, 32'h0,  0, 0, 4, 32'hF0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Read-only controller for the 2-way set-associative instruction cache (4 sets, 16-byte lines) between the fetch stage and the memory bus. It runs the tag lookup, chooses the refill way from the shared `lru` block, fetches a missing line as four 32-bit beats, and returns the requested word to fetch. The tag, valid and data arrays are registers held inside this block.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width, fixed
- Set, way and line geometry (4 / 2 / 4 words) are constants from `cache_pkg`, not parameters.

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- cpu_req_valid  in  1  fetch request
- cpu_req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_req_ready  out  1  high only in IDLE
- cpu_resp_valid  out  1  one-cycle pulse carrying the response
- cpu_resp_data  out  DATA_W  requested word
- flush  in  1  invalidates all lines; sampled in IDLE only
- mem_req_valid  out  1  line-fill request
- mem_req_addr  out  ADDR_W  line base address, bits [3:0] = 0
- mem_req_ready  in  1  bus accepts the request
- mem_rdata_valid  in  1  beat valid
- mem_rdata  in  DATA_W  beat data, word 0..3 in order

## Operation
- Address split: offset [3:2], index [5:4], tag [31:6] (26 bits).
- States and transitions:
  - IDLE:
    - if flush: clear all 8 valid bits; stay in IDLE; the request is not accepted this cycle.
    - else if cpu_req_valid: latch the address, go to LOOKUP.
  - LOOKUP: compute hit_w = valid[w][idx] && tag[w][idx] == tag.
    - On a hit: cpu_resp_valid=1 with the data from the hit way, drive LRU update_en with hit0/hit1, then go to IDLE.
    - On a miss: latch victim_way from `lru` at this index, go to MISS_REQ.
  - MISS_REQ: mem_req_valid=1 with the line address.
    - valid/addr stay stable until mem_req_ready.
    - On the handshake: clear valid[victim][idx], go to REFILL.
  - REFILL: beat counter runs 0..3.
    - Each mem_rdata_valid writes data[victim][idx][cnt].
    - Gaps between beats are allowed.
    - On beat 3: write the tag, set valid, go to RESP.
  - RESP: cpu_resp_valid=1 with the data at the latched offset; LRU update_en with the refilled way's hit bit; go to IDLE.
- Both ways hitting cannot happen by construction. If it does, way 0 wins.
- While both ways of a set are invalid, victim_way from `lru` (reset value 0) selects way 0.
- mem_rdata_valid outside REFILL is ignored.
- cpu_req_addr is not re-sampled after acceptance.

## Timing
- Reset (next edge):
  - state IDLE, all valid bits 0, beat counter 0.
  - cpu_resp_valid=0, mem_req_valid=0, cpu_resp_data=0, mem_req_addr=0.
  - cpu_req_ready=1 from the first post-reset cycle.
- Hit latency: request accepted at edge N, cpu_resp_valid during cycle N+1, ready again at N+2.
- Miss latency: 1 (LOOKUP) + request wait + 4 beats (plus gaps) + 1 (RESP).
  - Minimum: accept at N, mem_req_valid in N+2, beats in N+3..N+6, response in N+7.
- cpu_resp_valid is never high for two consecutive cycles; there is no back-pressure on the response.
- Reset mid-refill:
  - abort and return to IDLE.
  - the victim line stays invalid, because valid is set only on beat 3.
  - the memory side is reset by the same rst.
- Flush and cpu_req_valid in the same IDLE cycle: flush wins and the request waits one cycle.

## Structure
- `cache_pkg` holds:
  - the constants NUM_SETS=4, NUM_WAYS=2, LINE_WORDS=4, OFFSET_LSB=2, INDEX_LSB=4, TAG_LSB=6
  - the state enum {IDLE, LOOKUP, MISS_REQ, REFILL, RESP}
- Sub-module: the existing `lru` instance (clk, rst, index, update_en, hit0, hit1, victim_way), driven only by this block.
- Arrays: registers, reset by valid bits only; data and tag are not reset.

## Test plan
- Cold miss:
  - stimulus: reset, request 0x0000_0044; memory returns 0xA0..0xA3 with no gaps.
  - required: mem_req_addr=0x0000_0040; response 0xA1 at N+7; valid[0][0] set.
- Hit after fill:
  - stimulus: repeat 0x0000_004C.
  - required: response 0xA3 at N+1; no mem_req_valid.
- Conflict and LRU:
  - stimulus: fill 0x040 (way 0), then 0x440 (same set), then 0x840.
  - required: 0x440 → way 1; 0x840 replaces way 0.
  - stimulus: access 0x440 again.
  - required: it still hits.
- Stalled bus:
  - stimulus: hold mem_req_ready=0 for 5 cycles, then insert 2-cycle gaps between beats.
  - required: mem_req_valid and mem_req_addr stable throughout; correct word returned; exactly one response.
- Reset mid-refill:
  - stimulus: assert rst after beat 2.
  - required: IDLE, cpu_req_ready=1; re-requesting the same address misses and refetches.
- Flush:
  - stimulus: fill two sets, pulse flush in IDLE together with a request.
  - required: the request is held one cycle, then misses; all previous lines miss.
